// File: rtl/sdram_burst_data_path_pkg.sv
// Shared definitions for the SDRAM burst data path: FSM encodings, read tag
// record and counter sizing helper.
package sdram_burst_data_path_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

    // Beat counter is wide enough to hold BURST_LEN itself.
    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/sdram_burst_data_path_rd_capture.sv
// Read capture: CAS-latency-deep {valid,last} shift line feeding the DQIN
// capture register; also reports whether any read beat is still in flight.
module sdram_burst_data_path_rd_capture
    import sdram_burst_data_path_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CAS_LATENCY = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  rd_tag_t               issue,
    input  logic [DATA_WIDTH-1:0] DQIN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  RD_LAST,
    output logic                  inflight
);

    logic [CAS_LATENCY-1:0] vld;
    logic [CAS_LATENCY-1:0] lst;

    // The tag at the tail of the line marks the cycle in which the SDRAM drives DQ.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld      <= '0;
            lst      <= '0;
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
        end else begin
            vld      <= {vld[CAS_LATENCY-2:0], issue.valid};
            lst      <= {lst[CAS_LATENCY-2:0], issue.last};
            RD_VALID <= vld[CAS_LATENCY-1];
            RD_LAST  <= vld[CAS_LATENCY-1] & lst[CAS_LATENCY-1];
            if (vld[CAS_LATENCY-1]) begin
                RD_DATA <= DQIN;
            end
        end
    end

    assign inflight = |vld;

endmodule

// File: rtl/sdram_burst_data_path.sv
// SDRAM DQ/DQM burst data path: sequences write beats onto the pads, issues
// read capture tags, and enforces turnaround and start-request rules.
module sdram_burst_data_path
    import sdram_burst_data_path_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CAS_LATENCY = 3,
    parameter int BURST_LEN   = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    INIT_DONE,
    input  logic                    WR_START,
    input  logic [DATA_WIDTH-1:0]   DATAIN,
    input  logic [DATA_WIDTH/8-1:0] DM,
    output logic                    WR_ACK,
    input  logic                    RD_START,
    input  logic                    BURST_STOP,
    input  logic [DATA_WIDTH-1:0]   DQIN,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic                    RD_VALID,
    output logic                    RD_LAST,
    output logic [DATA_WIDTH-1:0]   DQOUT,
    output logic                    DQ_OE,
    output logic [DATA_WIDTH/8-1:0] DQM,
    output logic                    BUSY,
    output logic                    PROTO_ERR
);

    localparam int              CW       = cnt_width(BURST_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BURST_LEN - 1);

    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          rd_accept, wr_accept, wr_ack, err_nx, rd_inflight;
    rd_tag_t       issue;

    // WR_ACK handshake: the beat on DATAIN/DM is taken in any cycle WR_ACK is
    // high; beat 0 is taken in the WR_START cycle itself, and there is no stall.
    always_comb begin
        rd_accept   = RD_START && (state != ST_WRITE);
        wr_accept   = WR_START && (state == ST_IDLE) && !rd_inflight && !RD_START;
        wr_ack      = wr_accept || ((state == ST_WRITE) && !BURST_STOP);
        err_nx      = (WR_START && !wr_accept) || (RD_START && (state == ST_WRITE));
        issue.valid = rd_accept || ((state == ST_READ) && !BURST_STOP);
        issue.last  = rd_accept ? (BURST_LEN == 1) : (cnt == CNT_LAST);

        state_nx = state;
        cnt_nx   = cnt;
        // cnt holds the index of the beat handled in the current cycle.
        if (rd_accept) begin
            cnt_nx   = CW'(1);
            state_nx = (BURST_LEN == 1) ? ST_IDLE : ST_READ;
        end else if (wr_accept) begin
            cnt_nx   = CW'(1);
            state_nx = (BURST_LEN == 1) ? ST_IDLE : ST_WRITE;
        end else if ((state == ST_WRITE) || (state == ST_READ)) begin
            if (BURST_STOP || (cnt == CNT_LAST)) begin
                state_nx = ST_IDLE;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            DQOUT     <= '0;
            DQ_OE     <= 1'b0;
            DQM       <= '1;
            PROTO_ERR <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            DQ_OE     <= wr_ack;
            PROTO_ERR <= err_nx;
            if (wr_ack) begin
                DQOUT <= DATAIN;
            end
            // Mask stays forced high until the SDRAM has finished power-up init.
            DQM <= !INIT_DONE ? '1 : (wr_ack ? DM : '0);
        end
    end

    sdram_burst_data_path_rd_capture #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CAS_LATENCY (CAS_LATENCY)
    ) u_rd_capture (
        .CLK      (CLK),
        .RESET    (RESET),
        .issue    (issue),
        .DQIN     (DQIN),
        .RD_DATA  (RD_DATA),
        .RD_VALID (RD_VALID),
        .RD_LAST  (RD_LAST),
        .inflight (rd_inflight)
    );

    assign WR_ACK = wr_ack;
    assign BUSY   = (state != ST_IDLE) || rd_inflight || RD_VALID;

endmodule

// File: tb/tb_sdram_burst_data_path.sv
// Directed bench for sdram_burst_data_path: four parameterisations share one
// stimulus bus; each scenario checks the instance whose parameters it targets.
module tb_sdram_burst_data_path;

    logic        CLK = 1'b0;
    logic        RESET, INIT_DONE, WR_START, RD_START, BURST_STOP;
    logic [15:0] DATAIN, DQIN;
    logic [1:0]  DM;

    // a: CL3/BL8, b: CL3/BL4, c: CL2/BL4, d: CL2/BL1
    logic        wr_ack_a, rd_valid_a, rd_last_a, dq_oe_a, busy_a, proto_err_a;
    logic        wr_ack_b, rd_valid_b, rd_last_b, dq_oe_b, busy_b, proto_err_b;
    logic        wr_ack_c, rd_valid_c, rd_last_c, dq_oe_c, busy_c, proto_err_c;
    logic        wr_ack_d, rd_valid_d, rd_last_d, dq_oe_d, busy_d, proto_err_d;
    logic [15:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;
    logic [15:0] dqout_a, dqout_b, dqout_c, dqout_d;
    logic [1:0]  dqm_a, dqm_b, dqm_c, dqm_d;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr_start;
        logic [15:0] datain;
        logic [1:0]  dm;
        logic        exp_ack;
        logic        exp_oe;
        logic [15:0] exp_dq;
        logic [1:0]  exp_dqm;
    } wvec_t;

    wvec_t wtab[10];

    always #5 CLK = ~CLK;

    sdram_burst_data_path #(.DATA_WIDTH(16), .CAS_LATENCY(3), .BURST_LEN(8)) u_a (
        .CLK(CLK), .RESET(RESET), .INIT_DONE(INIT_DONE), .WR_START(WR_START), .DATAIN(DATAIN),
        .DM(DM), .WR_ACK(wr_ack_a), .RD_START(RD_START), .BURST_STOP(BURST_STOP), .DQIN(DQIN),
        .RD_DATA(rd_data_a), .RD_VALID(rd_valid_a), .RD_LAST(rd_last_a), .DQOUT(dqout_a),
        .DQ_OE(dq_oe_a), .DQM(dqm_a), .BUSY(busy_a), .PROTO_ERR(proto_err_a));

    sdram_burst_data_path #(.DATA_WIDTH(16), .CAS_LATENCY(3), .BURST_LEN(4)) u_b (
        .CLK(CLK), .RESET(RESET), .INIT_DONE(INIT_DONE), .WR_START(WR_START), .DATAIN(DATAIN),
        .DM(DM), .WR_ACK(wr_ack_b), .RD_START(RD_START), .BURST_STOP(BURST_STOP), .DQIN(DQIN),
        .RD_DATA(rd_data_b), .RD_VALID(rd_valid_b), .RD_LAST(rd_last_b), .DQOUT(dqout_b),
        .DQ_OE(dq_oe_b), .DQM(dqm_b), .BUSY(busy_b), .PROTO_ERR(proto_err_b));

    sdram_burst_data_path #(.DATA_WIDTH(16), .CAS_LATENCY(2), .BURST_LEN(4)) u_c (
        .CLK(CLK), .RESET(RESET), .INIT_DONE(INIT_DONE), .WR_START(WR_START), .DATAIN(DATAIN),
        .DM(DM), .WR_ACK(wr_ack_c), .RD_START(RD_START), .BURST_STOP(BURST_STOP), .DQIN(DQIN),
        .RD_DATA(rd_data_c), .RD_VALID(rd_valid_c), .RD_LAST(rd_last_c), .DQOUT(dqout_c),
        .DQ_OE(dq_oe_c), .DQM(dqm_c), .BUSY(busy_c), .PROTO_ERR(proto_err_c));

    sdram_burst_data_path #(.DATA_WIDTH(16), .CAS_LATENCY(2), .BURST_LEN(1)) u_d (
        .CLK(CLK), .RESET(RESET), .INIT_DONE(INIT_DONE), .WR_START(WR_START), .DATAIN(DATAIN),
        .DM(DM), .WR_ACK(wr_ack_d), .RD_START(RD_START), .BURST_STOP(BURST_STOP), .DQIN(DQIN),
        .RD_DATA(rd_data_d), .RD_VALID(rd_valid_d), .RD_LAST(rd_last_d), .DQOUT(dqout_d),
        .DQ_OE(dq_oe_d), .DQM(dqm_d), .BUSY(busy_d), .PROTO_ERR(proto_err_d));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        WR_START   = 1'b0;
        RD_START   = 1'b0;
        BURST_STOP = 1'b0;
        DATAIN     = '0;
        DM         = '0;
    endtask

    task automatic gap(input int n);
        idle_inputs();
        repeat (n) next_cycle();
    endtask

    initial begin
        int nv;
        int noe;

        for (int i = 0; i < 10; i++) begin
            wtab[i].wr_start = (i == 0);
            wtab[i].datain   = (i < 8) ? 16'h1000 + 16'(i) : 16'hDEAD;
            wtab[i].dm       = (i == 3) ? 2'b01 : 2'b00;
            wtab[i].exp_ack  = (i < 8);
            wtab[i].exp_oe   = (i >= 1) && (i <= 8);
            wtab[i].exp_dq   = 16'h1000 + 16'(i) - 16'd1;
            wtab[i].exp_dqm  = (i == 4) ? 2'b01 : 2'b00;
        end

        RESET     = 1'b1;
        INIT_DONE = 1'b0;
        DQIN      = '0;
        idle_inputs();
        repeat (3) next_cycle();

        // reset state
        @(negedge CLK);
        chk("rst_dqm",       32'(dqm_a), 32'h3);
        chk("rst_dq_oe",     32'(dq_oe_a), 32'h0);
        chk("rst_dqout",     32'(dqout_a), 32'h0);
        chk("rst_rd_data",   32'(rd_data_a), 32'h0);
        chk("rst_rd_valid",  32'(rd_valid_a), 32'h0);
        chk("rst_rd_last",   32'(rd_last_a), 32'h0);
        chk("rst_proto_err", 32'(proto_err_a), 32'h0);
        chk("rst_busy",      32'(busy_a), 32'h0);
        next_cycle();
        RESET = 1'b0;
        gap(2);

        // write before init: mask forced high on every beat
        for (int i = 0; i < 10; i++) begin
            WR_START = (i == 0);
            DATAIN   = 16'h2000 + 16'(i);
            DM       = 2'b00;
            @(negedge CLK);
            if (i >= 1 && i <= 8) begin
                chk("noinit_dqm",   32'(dqm_a), 32'h3);
                chk("noinit_dq_oe", 32'(dq_oe_a), 32'h1);
            end
            next_cycle();
        end
        INIT_DONE = 1'b1;
        gap(3);
        @(negedge CLK);
        chk("idle_dqm_a", 32'(dqm_a), 32'h0);
        chk("idle_dqm_c", 32'(dqm_c), 32'h0);
        next_cycle();
        gap(2);

        // BL8 write burst with a masked byte on beat 3
        for (int i = 0; i < 10; i++) begin
            WR_START = wtab[i].wr_start;
            DATAIN   = wtab[i].datain;
            DM       = wtab[i].dm;
            @(negedge CLK);
            chk("wr_ack", 32'(wr_ack_a), 32'(wtab[i].exp_ack));
            chk("wr_oe",  32'(dq_oe_a), 32'(wtab[i].exp_oe));
            chk("wr_dqm", 32'(dqm_a), 32'(wtab[i].exp_dqm));
            if (wtab[i].exp_oe) chk("wr_dqout", 32'(dqout_a), 32'(wtab[i].exp_dq));
            next_cycle();
        end
        gap(4);

        // CL3/BL4 read
        for (int i = 0; i < 10; i++) begin
            RD_START = (i == 0);
            DQIN     = 16'h00A0 + 16'(i) - 16'd3;
            @(negedge CLK);
            chk("rd_valid", 32'(rd_valid_b), 32'((i >= 4) && (i <= 7)));
            if ((i >= 4) && (i <= 7)) chk("rd_data", 32'(rd_data_b), 32'h00A0 + 32'(i) - 32'd4);
            chk("rd_last", 32'(rd_last_b), 32'(i == 7));
            next_cycle();
        end
        gap(6);

        // CL2/BL4 read interrupted by a second read
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            RD_START = (i == 0) || (i == 2);
            DQIN     = 16'h0B00 + 16'(i);
            @(negedge CLK);
            if (i >= 1) chk("rr_busy", 32'(busy_c), 32'(i <= 8));
            chk("rr_valid", 32'(rd_valid_c), 32'((i >= 3) && (i <= 8)));
            chk("rr_last",  32'(rd_last_c), 32'(i == 8));
            if (rd_valid_c) nv++;
            next_cycle();
        end
        chk("rr_beats", 32'(nv), 32'd6);
        gap(8);

        // write rejected while read beats are in flight
        for (int i = 0; i < 7; i++) begin
            RD_START = (i == 0);
            WR_START = (i == 4);
            DATAIN   = 16'h3000;
            @(negedge CLK);
            chk("turn_err", 32'(proto_err_b), 32'(i == 5));
            if (i >= 1) chk("turn_oe", 32'(dq_oe_b), 32'h0);
            next_cycle();
        end
        gap(6);

        // write stopped at beat 2, read rejected mid-write
        noe = 0;
        for (int i = 0; i < 6; i++) begin
            WR_START   = (i == 0);
            RD_START   = (i == 1);
            BURST_STOP = (i == 2);
            DATAIN     = 16'h4000 + 16'(i);
            @(negedge CLK);
            chk("stop_ack", 32'(wr_ack_b), 32'(i <= 1));
            chk("stop_oe",  32'(dq_oe_b), 32'((i == 1) || (i == 2)));
            if ((i == 1) || (i == 2)) chk("stop_dqout", 32'(dqout_b), 32'h4000 + 32'(i) - 32'd1);
            chk("stop_err", 32'(proto_err_b), 32'(i == 2));
            if (dq_oe_b) noe++;
            next_cycle();
        end
        chk("stop_beats", 32'(noe), 32'd2);
        gap(4);

        // simultaneous starts: read wins, write rejected
        for (int i = 0; i < 6; i++) begin
            WR_START = (i == 0);
            RD_START = (i == 0);
            DQIN     = 16'h5000 + 16'(i);
            @(negedge CLK);
            chk("both_err",   32'(proto_err_b), 32'(i == 1));
            chk("both_oe",    32'(dq_oe_b), 32'h0);
            chk("both_valid", 32'(rd_valid_b), 32'(i >= 4));
            if (i == 4) chk("both_data", 32'(rd_data_b), 32'h5003);
            next_cycle();
        end
        gap(8);

        // reset during a read: CL3/BL4 on b, CL2/BL1 on d
        for (int i = 0; i < 11; i++) begin
            RD_START = (i <= 3);
            RESET    = (i == 3);
            DQIN     = 16'h00C0 + 16'(i);
            @(negedge CLK);
            if (i == 3) begin
                chk("bl1_valid", 32'(rd_valid_d), 32'h1);
                chk("bl1_last",  32'(rd_last_d), 32'h1);
                chk("bl1_data",  32'(rd_data_d), 32'h00C2);
                chk("pre_rst_valid_b", 32'(rd_valid_b), 32'h0);
            end
            if (i == 4) begin
                chk("mid_rst_valid_b", 32'(rd_valid_b), 32'h0);
                chk("mid_rst_dqm_b",   32'(dqm_b), 32'h3);
                chk("mid_rst_busy_b",  32'(busy_b), 32'h0);
                chk("mid_rst_valid_d", 32'(rd_valid_d), 32'h0);
                chk("mid_rst_busy_d",  32'(busy_d), 32'h0);
            end
            if (i >= 5) begin
                chk("post_rst_valid_b", 32'(rd_valid_b), 32'h0);
                chk("post_rst_valid_d", 32'(rd_valid_d), 32'h0);
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
